// File: rtl/rgb_to_gray_seq.sv
// rtl/rgb_to_gray_seq.sv - sequential shift-add RGB to luma converter, one term per clock
// Optional round-half-up with saturation: define RGB_TO_GRAY_SEQ_ROUND_EN
module rgb_to_gray_seq #(
  parameter int n        = 8,
  parameter int m        = 8,
  parameter int fidelity = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] r,
  input  logic [n-1:0] g,
  input  logic [n-1:0] b,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [m-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam int S  = (fidelity == 1) ? 4 : (fidelity == 2) ? 5 : 7;
  localparam int W  = n + S;
  localparam int F  = (fidelity == 1) ? 5 : (fidelity == 2) ? 8 : 10;
  localparam int SW = $clog2(F);
  localparam logic [SW-1:0] LAST = SW'(F - 1);

  if (fidelity < 1 || fidelity > 3) begin : g_bad_fidelity
    $error("rgb_to_gray_seq: fidelity must be 1, 2 or 3");
  end
  if (m < 1 || m > n + 4) begin : g_bad_width
    $error("rgb_to_gray_seq: m must be in 1..n+4");
  end

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  typedef enum logic [1:0] {CH_R, CH_G, CH_B} ch_t;

  state_t        state, state_nx;
  logic [n-1:0]  r_q, g_q, b_q;
  logic [W-1:0]  acc, acc_add, term;
  logic [SW-1:0] step;
  logic [n-1:0]  sel;
  ch_t           ch;
  logic [2:0]    sh;
  logic          load, add;

  // Term table: which latched channel and how far it is shifted at each step
  always_comb begin
    ch = CH_R;
    sh = 3'd0;
    case (fidelity)
      1: case (int'(step))
        0: ch = CH_B;
        1: ch = CH_R;
        2: begin ch = CH_R; sh = 3'd1; end
        3: begin ch = CH_G; sh = 3'd2; end
        4: begin ch = CH_G; sh = 3'd3; end
        default: ;
      endcase
      2: case (int'(step))
        0: ch = CH_R;
        1: ch = CH_G;
        2: begin ch = CH_R; sh = 3'd1; end
        3: begin ch = CH_G; sh = 3'd1; end
        4: begin ch = CH_B; sh = 3'd1; end
        5: begin ch = CH_R; sh = 3'd2; end
        6: begin ch = CH_G; sh = 3'd2; end
        7: begin ch = CH_G; sh = 3'd4; end
        default: ;
      endcase
      default: case (int'(step))
        0: ch = CH_R;
        1: ch = CH_B;
        2: begin ch = CH_R; sh = 3'd1; end
        3: begin ch = CH_G; sh = 3'd2; end
        4: begin ch = CH_R; sh = 3'd3; end
        5: begin ch = CH_G; sh = 3'd3; end
        6: begin ch = CH_B; sh = 3'd3; end
        7: begin ch = CH_R; sh = 3'd4; end
        8: begin ch = CH_G; sh = 3'd4; end
        9: begin ch = CH_G; sh = 3'd6; end
        default: ;
      endcase
    endcase
  end

  assign sel  = (ch == CH_R) ? r_q : (ch == CH_G) ? g_q : b_q;
  assign term = W'(sel) << sh;

`ifdef RGB_TO_GRAY_SEQ_ROUND_EN
  localparam logic [W-1:0] ACC_INIT = (W > m) ? (W'(1) << ((W > m) ? (W - m - 1) : 0)) : '0;
  logic [W:0] sum;
  assign sum     = {1'b0, acc} + {1'b0, term};
  assign acc_add = sum[W] ? '1 : sum[W-1:0];
`else
  localparam logic [W-1:0] ACC_INIT = '0;
  assign acc_add = acc + term;
`endif

  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    add       = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load     = 1'b1;
          state_nx = ACC;
        end
      end
      ACC: begin
        busy = 1'b1;
        add  = 1'b1;
        if (step == LAST) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        in_ready  = out_ready;
        // Output and input handshakes may complete together: reload without idling
        if (out_ready) begin
          if (in_valid) begin
            load     = 1'b1;
            state_nx = ACC;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      step  <= '0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        r_q  <= r;
        g_q  <= g;
        b_q  <= b;
        acc  <= ACC_INIT;
        step <= '0;
      end else if (add) begin
        acc  <= acc_add;
        step <= step + 1'b1;
      end
    end
  end

  assign y = acc[W-1:W-m];

endmodule

// File: tb/tb_rgb_to_gray_seq.sv
// tb/tb_rgb_to_gray_seq.sv - bench for rgb_to_gray_seq, fidelities 1..3 side by side
module tb_rgb_to_gray_seq;

  logic       clk;
  logic       rst;
  logic [7:0] r_s [3];
  logic [7:0] g_s [3];
  logic [7:0] b_s [3];
  logic       in_valid_s [3];
  logic       in_ready_s [3];
  logic [7:0] y_s [3];
  logic       out_valid_s [3];
  logic       out_ready_s [3];
  logic       busy_s [3];

  int checks = 0;
  int errors = 0;
  int lat_tab [3] = '{6, 9, 11};

`ifdef RGB_TO_GRAY_SEQ_ROUND_EN
  localparam int EXP_R2 = 56, EXP_B2 = 16, EXP_R1 = 48, EXP_R3 = 54;
`else
  localparam int EXP_R2 = 55, EXP_B2 = 15, EXP_R1 = 47, EXP_R3 = 53;
`endif

  for (genvar k = 0; k < 3; k++) begin : g_dut
    rgb_to_gray_seq #(.n(8), .m(8), .fidelity(k + 1)) dut (
      .clk(clk), .rst(rst),
      .r(r_s[k]), .g(g_s[k]), .b(b_s[k]),
      .in_valid(in_valid_s[k]), .in_ready(in_ready_s[k]),
      .y(y_s[k]), .out_valid(out_valid_s[k]), .out_ready(out_ready_s[k]),
      .busy(busy_s[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Luma from the coefficient fractions directly
  function automatic int gray(int f, int rr, int gg, int bb);
    int s, sum;
    case (f)
      1:       begin s = 4; sum = 3 * rr + 12 * gg + bb; end
      2:       begin s = 5; sum = 7 * rr + 23 * gg + 2 * bb; end
      default: begin s = 7; sum = 27 * rr + 92 * gg + 9 * bb; end
    endcase
`ifdef RGB_TO_GRAY_SEQ_ROUND_EN
    sum = sum + (1 << (s - 1));
`endif
    sum = sum >> s;
    if (sum > 255) sum = 255;
    return sum;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Per-cycle compare against the handshake-level model
  initial begin
    int cyc;
    bit pend [3];
    int hs_cyc [3];
    int exp_y [3];
    cyc = 0;
    for (int k = 0; k < 3; k++) begin pend[k] = 0; hs_cyc[k] = 0; exp_y[k] = 0; end
    forever begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          pend[k] = 0;
          chk("mon_rst_in_ready", int'(in_ready_s[k]), 1);
          chk("mon_rst_out_valid", int'(out_valid_s[k]), 0);
          chk("mon_rst_busy", int'(busy_s[k]), 0);
          chk("mon_rst_y", int'(y_s[k]), 0);
        end else begin
          if (pend[k]) begin
            chk("mon_out_valid", int'(out_valid_s[k]), int'((cyc - hs_cyc[k]) >= lat_tab[k]));
            chk("mon_busy", int'(busy_s[k]), 1);
            if (out_valid_s[k]) begin
              chk("mon_y", int'(y_s[k]), exp_y[k]);
              chk("mon_in_ready_done", int'(in_ready_s[k]), int'(out_ready_s[k]));
            end else begin
              chk("mon_in_ready_acc", int'(in_ready_s[k]), 0);
            end
          end else begin
            chk("mon_idle_out_valid", int'(out_valid_s[k]), 0);
            chk("mon_idle_in_ready", int'(in_ready_s[k]), 1);
            chk("mon_idle_busy", int'(busy_s[k]), 0);
          end
          if (out_valid_s[k] && out_ready_s[k]) pend[k] = 0;
          if (in_valid_s[k] && in_ready_s[k]) begin
            pend[k]   = 1;
            hs_cyc[k] = cyc;
            exp_y[k]  = gray(k + 1, int'(r_s[k]), int'(g_s[k]), int'(b_s[k]));
          end
        end
      end
    end
  end

  task automatic send(int k, int rr, int gg, int bb);
    bit ok;
    ok = 0;
    r_s[k] = 8'(rr); g_s[k] = 8'(gg); b_s[k] = 8'(bb);
    in_valid_s[k] = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready_s[k];
    end
    chk("send_in_ready", int'(ok), 1);
    @(posedge clk); #1;
    in_valid_s[k] = 1'b0;
  endtask

  task automatic wait_out(int k, string nm, output int lat);
    bit seen;
    seen = 0;
    lat  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      seen = out_valid_s[k];
    end
    chk({nm, "_seen"}, int'(seen), 1);
  endtask

  task automatic run_pixel(int k, int rr, int gg, int bb, int exp, string nm);
    int lat;
    send(k, rr, gg, bb);
    wait_out(k, nm, lat);
    chk({nm, "_latency"}, lat, lat_tab[k]);
    chk({nm, "_y"}, int'(y_s[k]), exp);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, y0, waited, nr, ng, nb;
    bit ok;
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, y0, waited, nr, ng, nb;
    bit ok;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      r_s[k] = '0; g_s[k] = '0; b_s[k] = '0;
      in_valid_s[k] = 1'b0; out_ready_s[k] = 1'b1;
    end

    chk("model_white_f2", gray(2, 255, 255, 255), 255);
    chk("model_green_f2", gray(2, 0, 255, 0), 183);
    chk("model_red_f2", gray(2, 255, 0, 0), EXP_R2);
    chk("model_blue_f2", gray(2, 0, 0, 255), EXP_B2);
    chk("model_red_f1", gray(1, 255, 0, 0), EXP_R1);
    chk("model_red_f3", gray(3, 255, 0, 0), EXP_R3);

    repeat (2) @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_in_ready", int'(in_ready_s[k]), 1);
      chk("reset_out_valid", int'(out_valid_s[k]), 0);
      chk("reset_busy", int'(busy_s[k]), 0);
      chk("reset_y", int'(y_s[k]), 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    run_pixel(1, 255, 255, 255, 255, "f2_white");
    run_pixel(1, 0, 255, 0, 183, "f2_green");
    run_pixel(1, 255, 0, 0, EXP_R2, "f2_red");
    run_pixel(1, 0, 0, 255, EXP_B2, "f2_blue");
    run_pixel(0, 255, 255, 255, 255, "f1_white");
    run_pixel(0, 255, 0, 0, EXP_R1, "f1_red");
    run_pixel(2, 255, 255, 255, 255, "f3_white");
    run_pixel(2, 255, 0, 0, EXP_R3, "f3_red");

    // Backpressure: hold the result, then handshake out and in on the same edge
    out_ready_s[1] = 1'b0;
    send(1, 10, 20, 30);
    wait_out(1, "hold", lat);
    y0 = int'(y_s[1]);
    chk("hold_first_y", y0, gray(2, 10, 20, 30));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_y", int'(y_s[1]), y0);
      chk("hold_out_valid", int'(out_valid_s[1]), 1);
      chk("hold_in_ready", int'(in_ready_s[1]), 0);
    end
    @(posedge clk); #1;
    r_s[1] = 8'd200; g_s[1] = 8'd100; b_s[1] = 8'd50;
    in_valid_s[1] = 1'b1;
    out_ready_s[1] = 1'b1;
    @(negedge clk);
    chk("dual_in_ready", int'(in_ready_s[1]), 1);
    chk("dual_out_valid", int'(out_valid_s[1]), 1);
    @(posedge clk); #1;
    in_valid_s[1] = 1'b0;
    r_s[1] = 8'd7; g_s[1] = 8'd7; b_s[1] = 8'd7;
    wait_out(1, "dual_next", lat);
    chk("dual_next_latency", lat, 9);
    chk("dual_next_y", int'(y_s[1]), gray(2, 200, 100, 50));
    @(posedge clk); #1;

    // Back-to-back random stream, source always valid
    for (int i = 0; i < 16; i++) begin
      nr = int'($urandom_range(0, 255));
      ng = int'($urandom_range(0, 255));
      nb = int'($urandom_range(0, 255));
      r_s[1] = 8'(nr); g_s[1] = 8'(ng); b_s[1] = 8'(nb);
      in_valid_s[1] = 1'b1;
      ok = 0;
      waited = 0;
      for (int j = 0; j < 40 && !ok; j++) begin
        @(negedge clk);
        waited++;
        ok = in_ready_s[1];
      end
      chk("stream_in_ready", int'(ok), 1);
      if (i > 0) chk("stream_gap", waited, 9);
      @(posedge clk); #1;
    end
    in_valid_s[1] = 1'b0;
    wait_out(1, "stream_last", lat);
    chk("stream_last_latency", lat, 9);
    @(posedge clk); #1;

    // Asynchronous reset during the fourth accumulate cycle
    send(1, 255, 255, 255);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", int'(busy_s[1]), 0);
    chk("async_rst_in_ready", int'(in_ready_s[1]), 1);
    chk("async_rst_out_valid", int'(out_valid_s[1]), 0);
    chk("async_rst_y", int'(y_s[1]), 0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", int'(out_valid_s[1]), 0);
    end
    @(posedge clk); #1;
    run_pixel(1, 0, 255, 0, 183, "post_rst_green");
    run_pixel(1, 120, 60, 240, gray(2, 120, 60, 240), "post_rst_mix");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_to_gray_seq.md
Name: rgb_to_gray_seq

Overview:
Multi-cycle, area-minimal RGB-to-luma converter for iCE40 designs where LUTs are scarce.
- Computes the same CIE1931 rounded-coefficient weighted sum as the combinational converter.
- Sequences it through one shared accumulator adder, one shift-add term per clock, instead of a full adder tree.
- Sits between a pixel source and sink with valid/ready handshakes on both sides.

Parameters:
n, 8, bit width of each r/g/b input channel.
m, 8, bit width of y output; legal range 1..n+4.
fidelity, 2, coefficient set: 1 = 3/16,12/16,1/16; 2 = 7/32,23/32,2/32; 3 = 27/128,92/128,9/128; other values are illegal (elaboration error).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
r  input  n  red channel, sampled on input handshake.
g  input  n  green channel, sampled on input handshake.
b  input  n  blue channel, sampled on input handshake.
in_valid  input  1  source presents a pixel.
in_ready  output  1  block accepts a pixel this cycle.
y  output  m  grayscale result, stable while out_valid=1.
out_valid  output  1  y holds a finished result.
out_ready  input  1  sink accepts y this cycle.
busy  output  1  high in ACC or DONE state.

Behaviour:
- Constants:
  - S = 4/5/7 for fidelity 1/2/3.
  - Accumulator width W = n+S.
  - Term count F = 5/8/10.
- Term sequence, fixed order, index 0..F-1:
  - fidelity 1: b, r, r<<1, g<<2, g<<3.
  - fidelity 2: r, g, r<<1, g<<1, b<<1, r<<2, g<<2, g<<4.
  - fidelity 3: r, b, r<<1, g<<2, r<<3, g<<3, b<<3, r<<4, g<<4, g<<6.
- Registers: latched R/G/B (n each), acc (W), step counter (ceil(log2(F)) bits), 2-bit state.
- States:
  - IDLE: in_ready=1. On in_valid: latch r,g,b, acc<=0, step<=0, go to ACC.
  - ACC: in_ready=0. Each cycle acc <= acc + term[step], step <= step+1. When step==F-1, go to DONE after this add.
  - DONE: out_valid=1, y = acc[W-1 : W-m]; y and acc are frozen.
    - out_ready=0: stay in DONE.
    - out_ready=1 and in_valid=0: go to IDLE.
    - out_ready=1 and in_valid=1: the output and input handshakes complete in the same cycle. Latch the new pixel, clear acc, go directly to ACC.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational from out_ready; no combinational path from in_valid.
- Latency: input handshake at edge T0, out_valid high from cycle T0+F+1. Sustained throughput is one pixel per F+1 cycles.
- Arithmetic: terms are zero-extended to W before the add. The sum cannot exceed 2^S*(2^n-1), so the unrounded path never overflows.
- y is truncated, not rounded, unless the optional feature is enabled.
- Reset values: state=IDLE, acc=0, step=0, latched RGB=0. Outputs: in_ready=1, out_valid=0, busy=0, y=0.
- Reset asserted mid-ACC or mid-DONE: the in-flight pixel is discarded with no output. The first post-reset cycle is IDLE.
- Inputs r,g,b changing during ACC have no effect, because the latched copies are used.
- in_valid during ACC is ignored; the source must hold the pixel per valid/ready rules.

Optional Feature:
Macro RGB_TO_GRAY_SEQ_ROUND_EN.
- Defined, and W>m:
  - Acc is initialised to 2^(W-m-1) instead of 0 on every pixel load (round half up).
  - The final add saturates: if a carry out of W bits occurs, acc <= all ones.
  - Rounding adds no cycles.
- Not defined: acc starts at 0 and y is the plain truncation.
- If W==m the macro has no effect.

Test Plan:
- n=8, m=8, fidelity=2: r=g=b=255 -> y=255, out_valid rises exactly 9 cycles after the input handshake.
- r=0,g=255,b=0 -> y=183; r=255,g=0,b=0 -> y=55 (56 with RGB_TO_GRAY_SEQ_ROUND_EN); r=0,g=0,b=255 -> y=15 (16 with macro).
- Hold out_ready=0 for 20 cycles after a result: y and out_valid stay constant, in_ready=0. Then out_ready=1 with in_valid=1 and a new pixel: both handshakes occur in one cycle and the next result follows 9 cycles later.
- Back-to-back stream of 16 random pixels, out_ready always 1: every y matches the reference formula (truncated) and throughput is exactly 1 per 9 cycles.
- Assert rst in the 4th ACC cycle: outputs return to reset values immediately (asynchronously), no stale out_valid. The next pixel yields the correct result.
- fidelity=1 and fidelity=3 with r=g=b=255, n=8, m=8 -> y=255, latencies 6 and 11 cycles respectively; r=255,g=b=0 -> y=47 (fid 1), 53 (fid 3).
